imem_row_seq_decoder: RTL and testbench



---
 rtl/imem_row_seq_decoder_pkg.sv | 26 ++
 rtl/imem_row_seq_decoder_if.sv | 56 +++++
 rtl/imem_row_seq_decoder_onehot_dec.sv | 15 +
 rtl/imem_row_seq_decoder.sv | 128 ++++++++++++
 tb/tb_imem_row_seq_decoder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_row_seq_decoder_pkg.sv
// Shared types and helpers for the sequenced instruction-memory row decoder.
// Holds the FSM state enum, length-field width formula and length clamp.
package imem_dec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BEAT = 1'b1
  } state_e;

  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_BURST_MAX = 4;

  function automatic int len_w(input int bmax);
    return $clog2(bmax + 1);
  endfunction

  localparam int DEF_LEN_W = $clog2(DEF_BURST_MAX + 1);

  // A zero length still fetches one row; oversize bursts saturate.
  function automatic int clamp_len(input int len, input int bmax);
    if (len == 0) return 1;
    if (len > bmax) return bmax;
    return len;
  endfunction

endpackage

// File: rtl/imem_row_seq_decoder_if.sv
// Request/row-select bundle between fetch address logic and the decoder.
// IMEM_DEC_PARITY_EN adds req_addr_par and addr_err.
interface imem_row_seq_decoder_if
  import imem_dec_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int BURST_MAX = 4
);

  localparam int ROWS  = 2 ** ADDR_W;
  localparam int LEN_W = len_w(BURST_MAX);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [ROWS-1:0]   row_sel;
  logic              row_strobe;
  logic              row_last;
  logic              busy;
`ifdef IMEM_DEC_PARITY_EN
  logic              req_addr_par;
  logic              addr_err;
`endif

  modport master (
`ifdef IMEM_DEC_PARITY_EN
    output req_addr_par,
    input  addr_err,
`endif
    output req_valid,
    output req_addr,
    output req_len,
    input  req_ready,
    input  row_sel,
    input  row_strobe,
    input  row_last,
    input  busy
  );

  modport slave (
`ifdef IMEM_DEC_PARITY_EN
    input  req_addr_par,
    output addr_err,
`endif
    input  req_valid,
    input  req_addr,
    input  req_len,
    output req_ready,
    output row_sel,
    output row_strobe,
    output row_last,
    output busy
  );

endinterface

// File: rtl/imem_row_seq_decoder_onehot_dec.sv
// Combinational ADDR_W to 2**ADDR_W one-hot row decoder.
// No configuration macros.
module onehot_dec #(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic [2**ADDR_W-1:0]   onehot
);

  always_comb begin
    onehot       = '0;
    onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/imem_row_seq_decoder.sv
// Sequenced one-hot row-select decoder with wait states and bursts.
// IMEM_DEC_PARITY_EN enables request address parity checking.
module imem_row_seq_decoder
  import imem_dec_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int WAIT_CYCLES = 1,
  parameter int BURST_MAX   = 4
) (
  input  logic clk,
  input  logic reset,
  imem_row_seq_decoder_if.slave bus
);

  localparam int ROWS   = 2 ** ADDR_W;
  localparam int LEN_W  = len_w(BURST_MAX);
  localparam int WCNT_W =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST =
    WCNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              busy_q, busy_d;
  logic [ROWS-1:0]   row_sel_q, row_sel_d;
  logic              row_strobe_q, row_strobe_d;
  logic              row_last_q, row_last_d;
  logic [ROWS-1:0]   dec_out;
  logic              par_ok;

`ifdef IMEM_DEC_PARITY_EN
  logic err_q, err_d;
  assign par_ok = (bus.req_addr_par == ^bus.req_addr);
`else
  assign par_ok = 1'b1;
`endif

  // Decode the address the row register will hold next cycle.
  onehot_dec #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr   (addr_d),
    .onehot (dec_out)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    wcnt_d  = wcnt_q;
`ifdef IMEM_DEC_PARITY_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef IMEM_DEC_PARITY_EN
        err_d = bus.req_valid && !par_ok;
`endif
        if (bus.req_valid && par_ok) begin
          state_d = BEAT;
          addr_d  = bus.req_addr;
          left_d  = LEN_W'(clamp_len(
                      int'(bus.req_len), BURST_MAX));
          wcnt_d  = '0;
        end
      end
      BEAT: begin
        if (wcnt_q == WAIT_LAST) begin
          wcnt_d = '0;
          if (left_q <= LEN_W'(1)) begin
            state_d = IDLE;
            left_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            left_d = left_q - LEN_W'(1);
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d == BEAT);
    row_sel_d    = busy_d ? dec_out : '0;
    row_strobe_d = busy_d && (wcnt_d == WAIT_LAST);
    row_last_d   = row_strobe_d && (left_d == LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      left_q       <= '0;
      wcnt_q       <= '0;
      busy_q       <= 1'b0;
      row_sel_q    <= '0;
      row_strobe_q <= 1'b0;
      row_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      left_q       <= left_d;
      wcnt_q       <= wcnt_d;
      busy_q       <= busy_d;
      row_sel_q    <= row_sel_d;
      row_strobe_q <= row_strobe_d;
      row_last_q   <= row_last_d;
    end
  end

`ifdef IMEM_DEC_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign bus.addr_err = err_q;
`endif

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.row_sel    = row_sel_q;
  assign bus.row_strobe = row_strobe_q;
  assign bus.row_last   = row_last_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_imem_row_seq_decoder.sv
// Scoreboard bench for imem_row_seq_decoder (WAIT=1 and WAIT=0 instances).
// Define IMEM_DEC_PARITY_EN to also exercise the parity path.
module tb_imem_row_seq_decoder;

  typedef struct {
    int          cyc;
    logic [15:0] sel;
    logic        stb;
    logic        lst;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  imem_row_seq_decoder_if #(.ADDR_W(4), .BURST_MAX(4)) bus0();
  imem_row_seq_decoder_if #(.ADDR_W(4), .BURST_MAX(4)) bus1();

  imem_row_seq_decoder #(
    .ADDR_W(4), .WAIT_CYCLES(1), .BURST_MAX(4)
  ) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  imem_row_seq_decoder #(
    .ADDR_W(4), .WAIT_CYCLES(0), .BURST_MAX(4)
  ) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input int c,
                      input logic [15:0] s,
                      input logic st, input logic l);
    exp_t e;
    e.cyc = c; e.sel = s; e.stb = st; e.lst = l;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic push_burst(input int id, input int acc,
                            input int addr, input int nb,
                            input int w);
    logic [15:0] one;
    one = 16'd1;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k <= w; k++)
        push(id, acc + b * (w + 1) + k,
             one << ((addr + b) % 16),
             k == w, (k == w) && (b == nb - 1));
  endtask

  task automatic mon(input int id, input logic [15:0] sel,
                     input logic stb, input logic lst,
                     input logic bsy);
    exp_t e;
    int   n;
    n = (id == 0) ? q0.size() : q1.size();
    if (bsy) begin
      if (n == 0) begin
        chk(1'b0, $sformatf("u%0d_unexpected_beat", id),
            {14'd0, sel, stb, lst}, 32'd0);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk(cyc == e.cyc, $sformatf("u%0d_beat_cycle", id),
            cyc, e.cyc);
        chk({sel, stb, lst} == {e.sel, e.stb, e.lst},
            $sformatf("u%0d_beat_out", id),
            {14'd0, sel, stb, lst},
            {14'd0, e.sel, e.stb, e.lst});
      end
    end else begin
      chk(sel == 16'd0 && !stb && !lst,
          $sformatf("u%0d_idle_out", id),
          {14'd0, sel, stb, lst}, 32'd0);
      if (n > 0) begin
        e = (id == 0) ? q0[0] : q1[0];
        if (e.cyc < cyc) begin
          if (id == 0) void'(q0.pop_front());
          else         void'(q1.pop_front());
          chk(1'b0, $sformatf("u%0d_missed_beat", id),
              cyc, e.cyc);
        end
      end
    end
  endtask

  // Called at posedge+1; returns with acc = first row_sel cycle.
  task automatic issue(input int id, input logic [3:0] a,
                       input logic [2:0] l, input bit par_good,
                       output int acc);
    int   t;
    logic rdy;
    t = 0;
    if (id == 0) begin
      bus0.req_valid = 1'b1;
      bus0.req_addr  = a;
      bus0.req_len   = l;
`ifdef IMEM_DEC_PARITY_EN
      bus0.req_addr_par = (^a) ^ !par_good;
`endif
    end else begin
      bus1.req_valid = 1'b1;
      bus1.req_addr  = a;
      bus1.req_len   = l;
`ifdef IMEM_DEC_PARITY_EN
      bus1.req_addr_par = (^a) ^ !par_good;
`endif
    end
    rdy = (id == 0) ? bus0.req_ready : bus1.req_ready;
    while (!rdy && t < 50) begin
      @(posedge clk); #1;
      t++;
      rdy = (id == 0) ? bus0.req_ready : bus1.req_ready;
    end
    if (t >= 50)
      chk(1'b0, "accept_timeout", t, 50);
    @(posedge clk); #1;
    acc = cyc;
    if (id == 0) bus0.req_valid = 1'b0;
    else         bus1.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int id);
    int t;
    t = 0;
    while (((id == 0) ? (q0.size() > 0 || bus0.busy)
                      : (q1.size() > 0 || bus1.busy))
           && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100)
      chk(1'b0, $sformatf("u%0d_drain_timeout", id), t, 100);
  endtask

  initial begin
    int acc, acc_a, acc_b, t;
    bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.req_len = '0;
    bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_len = '0;
`ifdef IMEM_DEC_PARITY_EN
    bus0.req_addr_par = 1'b0;
    bus1.req_addr_par = 1'b0;
`endif

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          mon(0, bus0.row_sel, bus0.row_strobe,
              bus0.row_last, bus0.busy);
          mon(1, bus1.row_sel, bus1.row_strobe,
              bus1.row_last, bus1.busy);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk({bus0.req_ready, bus0.busy, bus0.row_sel,
         bus0.row_strobe, bus0.row_last} == {1'b1, 19'd0},
        "u0_reset_state",
        {12'd0, bus0.req_ready, bus0.busy, bus0.row_sel,
         bus0.row_strobe, bus0.row_last}, 32'h80000);
    chk({bus1.req_ready, bus1.busy, bus1.row_sel,
         bus1.row_strobe, bus1.row_last} == {1'b1, 19'd0},
        "u1_reset_state",
        {12'd0, bus1.req_ready, bus1.busy, bus1.row_sel,
         bus1.row_strobe, bus1.row_last}, 32'h80000);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single row, one wait state
    issue(0, 4'd3, 3'd1, 1'b1, acc);
    push(0, acc,     16'h0008, 1'b0, 1'b0);
    push(0, acc + 1, 16'h0008, 1'b1, 1'b1);
    wait_drain(0);

    // Wrapping burst, no wait states
    issue(1, 4'd14, 3'd4, 1'b1, acc);
    push(1, acc,     16'h4000, 1'b1, 1'b0);
    push(1, acc + 1, 16'h8000, 1'b1, 1'b0);
    push(1, acc + 2, 16'h0001, 1'b1, 1'b0);
    push(1, acc + 3, 16'h0002, 1'b1, 1'b1);
    wait_drain(1);

    // Length clamping
    issue(1, 4'd5, 3'd0, 1'b1, acc);
    push(1, acc, 16'h0020, 1'b1, 1'b1);
    wait_drain(1);
    issue(1, 4'd9, 3'd7, 1'b1, acc);
    push_burst(1, acc, 9, 4, 0);
    wait_drain(1);
    issue(0, 4'd12, 3'd7, 1'b1, acc);
    push_burst(0, acc, 12, 4, 1);
    wait_drain(0);

    // Reset during the second beat of a 3-row burst
    issue(0, 4'd2, 3'd3, 1'b1, acc);
    push_burst(0, acc, 2, 3, 1);
    t = 0;
    while (cyc < acc + 2 && t < 20) begin
      @(negedge clk);
      t++;
    end
    #1;
    reset = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    chk({bus0.req_ready, bus0.busy, bus0.row_sel,
         bus0.row_strobe, bus0.row_last} == {1'b1, 19'd0},
        "u0_mid_burst_reset",
        {12'd0, bus0.req_ready, bus0.busy, bus0.row_sel,
         bus0.row_strobe, bus0.row_last}, 32'h80000);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Request held through a burst waits for one IDLE cycle
    issue(0, 4'd7, 3'd2, 1'b1, acc_a);
    push_burst(0, acc_a, 7, 2, 1);
    issue(0, 4'd11, 3'd1, 1'b1, acc_b);
    push(0, acc_b,     16'h0800, 1'b0, 1'b0);
    push(0, acc_b + 1, 16'h0800, 1'b1, 1'b1);
    chk(acc_b == acc_a + 5, "held_req_gap", acc_b, acc_a + 5);
    wait_drain(0);

`ifdef IMEM_DEC_PARITY_EN
    issue(0, 4'd5, 3'd1, 1'b0, acc);
    @(negedge clk);
    chk({bus0.addr_err, bus0.req_ready, bus0.busy,
         bus0.row_sel} == {2'b11, 17'd0},
        "parity_err_pulse",
        {13'd0, bus0.addr_err, bus0.req_ready, bus0.busy,
         bus0.row_sel}, 32'h60000);
    @(negedge clk);
    chk(bus0.addr_err == 1'b0, "parity_err_clear",
        bus0.addr_err, 0);
    @(posedge clk); #1;
    issue(0, 4'd5, 3'd1, 1'b1, acc);
    push(0, acc,     16'h0020, 1'b0, 1'b0);
    push(0, acc + 1, 16'h0020, 1'b1, 1'b1);
    wait_drain(0);
    chk(bus0.addr_err == 1'b0, "parity_ok_no_err",
        bus0.addr_err, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk(q0.size() == 0, "u0_queue_empty", q0.size(), 0);
    chk(q1.size() == 0, "u1_queue_empty", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
